// File: rtl/adda_stream_proc.sv
// ADC-to-DAC stream processor: pass / delay / moving-average / ramp, plus peak-hold LEDs and sticky clip flag.
// Latency 2 clocks from i_sample_en to o_da_valid; no backpressure, accepts a sample on every strobe.
module adda_stream_proc #(
  parameter int DATA_W      = 8,
  parameter int DELAY_DEPTH = 16,
  parameter int AVG_LOG2    = 2,
  parameter int DECAY_LOG2  = 20
) (
  input  logic                           i_clk,
  input  logic                           reset,
  input  logic                           i_sample_en,
  input  logic [DATA_W-1:0]              i_ad_data,
  input  logic [1:0]                     i_mode,
  input  logic [$clog2(DELAY_DEPTH)-1:0] i_delay,
  input  logic                           i_clip_clr,
  output logic [DATA_W-1:0]              o_da_data,
  output logic                           o_da_valid,
  output logic [7:0]                     o_led,
  output logic                           o_clip
);

  localparam int PTR_W = $clog2(DELAY_DEPTH);
  localparam int AVG_N = 1 << AVG_LOG2;
  localparam int SUM_W = DATA_W + AVG_LOG2;
  localparam logic [DATA_W-1:0] FULL_SCALE = '1;

  logic [DATA_W-1:0]     s1_dat;
  logic                  s1_vld;
  logic [DATA_W-1:0]     dly_mem [DELAY_DEPTH];
  logic [PTR_W-1:0]      wp;
  logic [DATA_W-1:0]     avg_hist [AVG_N];
  logic [SUM_W-1:0]      sum;
  logic [SUM_W-1:0]      sum_nxt;
  logic [DATA_W-1:0]     ramp_cnt;
  logic [DATA_W-1:0]     peak;
  logic [DECAY_LOG2-1:0] dec_cnt;
  logic [DATA_W-1:0]     dly_res;
  logic [DATA_W-1:0]     mode_res;
  logic                  new_max;
  logic                  decay_tick;
  logic                  clip_hit;

  // The window sum always holds the last AVG_N samples, so it fits in SUM_W bits.
  always_comb begin
    sum_nxt    = sum + SUM_W'(s1_dat) - SUM_W'(avg_hist[AVG_N-1]);
    dly_res    = (i_delay == '0) ? s1_dat : dly_mem[wp - i_delay];
    new_max    = s1_vld && (s1_dat > peak);
    decay_tick = &dec_cnt;
    clip_hit   = s1_vld && ((s1_dat == '0) || (s1_dat == FULL_SCALE));
    mode_res   = s1_dat;
    case (i_mode)
      2'd0:    mode_res = s1_dat;
      2'd1:    mode_res = dly_res;
      2'd2:    mode_res = sum_nxt[AVG_LOG2 +: DATA_W];
      default: mode_res = ramp_cnt;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (reset) begin
      s1_dat     <= '0;
      s1_vld     <= 1'b0;
      o_da_data  <= '0;
      o_da_valid <= 1'b0;
      o_clip     <= 1'b0;
      wp         <= '0;
      sum        <= '0;
      ramp_cnt   <= '0;
      peak       <= '0;
      dec_cnt    <= '0;
      for (int i = 0; i < DELAY_DEPTH; i++) dly_mem[i] <= '0;
      for (int i = 0; i < AVG_N; i++) avg_hist[i] <= '0;
    end else begin
      s1_vld <= i_sample_en;
      if (i_sample_en) s1_dat <= i_ad_data;

      // Every mode's history advances on each sample so a mode switch never stalls.
      o_da_valid <= s1_vld;
      if (s1_vld) begin
        o_da_data   <= mode_res;
        dly_mem[wp] <= s1_dat;
        wp          <= wp + PTR_W'(1);
        sum         <= sum_nxt;
        ramp_cnt    <= ramp_cnt + DATA_W'(1);
        for (int i = AVG_N - 1; i > 0; i--) avg_hist[i] <= avg_hist[i-1];
        avg_hist[0] <= s1_dat;
      end

      if (new_max) begin
        peak    <= s1_dat;
        dec_cnt <= '0;
      end else begin
        dec_cnt <= dec_cnt + DECAY_LOG2'(1);
        if (decay_tick && (peak != '0)) peak <= peak - DATA_W'(1);
      end

      if (clip_hit)        o_clip <= 1'b1;
      else if (i_clip_clr) o_clip <= 1'b0;
    end
  end

  generate
    if (DATA_W >= 8) begin : g_led_msb
      assign o_led = peak[DATA_W-1 -: 8];
    end else begin : g_led_pad
      assign o_led = {peak, {(8-DATA_W){1'b0}}};
    end
  endgenerate

endmodule

// File: tb/tb_adda_stream_proc.sv
// Directed bench for adda_stream_proc, built with a short decay period so peak decay is observable.
module tb_adda_stream_proc;

  logic       i_clk;
  logic       reset;
  logic       i_sample_en;
  logic [7:0] i_ad_data;
  logic [1:0] i_mode;
  logic [3:0] i_delay;
  logic       i_clip_clr;
  logic [7:0] o_da_data;
  logic       o_da_valid;
  logic [7:0] o_led;
  logic       o_clip;

  int tests = 0;
  int fails = 0;
  logic [7:0] din_q[$];
  logic [7:0] exp_q[$];

  adda_stream_proc #(
    .DATA_W(8), .DELAY_DEPTH(16), .AVG_LOG2(2), .DECAY_LOG2(4)
  ) dut (
    .i_clk(i_clk), .reset(reset), .i_sample_en(i_sample_en), .i_ad_data(i_ad_data),
    .i_mode(i_mode), .i_delay(i_delay), .i_clip_clr(i_clip_clr),
    .o_da_data(o_da_data), .o_da_valid(o_da_valid), .o_led(o_led), .o_clip(o_clip)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_data"}, 32'(o_da_data), 32'h0);
    chk({tag, "_vld"},  32'(o_da_valid), 32'h0);
    chk({tag, "_led"},  32'(o_led), 32'h0);
    chk({tag, "_clip"}, 32'(o_clip), 32'h0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    i_sample_en = 1'b0;
    step();
    chk_zero("rst");
    reset = 1'b0;
  endtask

  // Full-rate stream of din_q; output k must equal exp_q[k] two clocks after its strobe.
  task automatic run_full(input string tag);
    int n;
    n = din_q.size();
    for (int i = 0; i <= n; i++) begin
      if (i < n) begin
        i_sample_en = 1'b1;
        i_ad_data   = din_q[i];
      end else begin
        i_sample_en = 1'b0;
      end
      step();
      if (i == 0) begin
        chk({tag, "_first_vld"}, 32'(o_da_valid), 32'h0);
      end else begin
        chk({tag, "_vld"}, 32'(o_da_valid), 32'h1);
        chk({tag, "_data"}, 32'(o_da_data), 32'(exp_q[i-1]));
      end
    end
    din_q.delete();
    exp_q.delete();
  endtask

  // One strobe followed by an idle clock.
  task automatic send_pair(input logic [7:0] d, input logic [7:0] exp, input string tag);
    i_sample_en = 1'b1;
    i_ad_data   = d;
    step();
    chk({tag, "_gap_vld"}, 32'(o_da_valid), 32'h0);
    i_sample_en = 1'b0;
    step();
    chk({tag, "_vld"}, 32'(o_da_valid), 32'h1);
    chk({tag, "_data"}, 32'(o_da_data), 32'(exp));
  endtask

  initial begin
    reset = 1'b1;
    i_sample_en = 1'b0;
    i_ad_data = 8'h00;
    i_mode = 2'd0;
    i_delay = 4'd0;
    i_clip_clr = 1'b0;
    step();
    step();
    chk_zero("init");

    // Passthrough
    reset = 1'b0;
    din_q = '{8'h10, 8'h20, 8'h30};
    exp_q = '{8'h10, 8'h20, 8'h30};
    run_full("pass");
    step();
    chk("pass_idle_vld", 32'(o_da_valid), 32'h0);
    chk("pass_hold", 32'(o_da_data), 32'h30);

    // Delay line, then depth-1 delay across the write-pointer wrap
    do_reset();
    i_mode = 2'd1;
    i_delay = 4'd3;
    din_q = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6};
    exp_q = '{8'd0, 8'd0, 8'd0, 8'd1, 8'd2, 8'd3};
    run_full("dly3");
    i_delay = 4'd15;
    for (int k = 0; k < 20; k++) begin
      din_q.push_back(8'(8'h40 + k));
      if (k < 9)       exp_q.push_back(8'h00);
      else if (k < 15) exp_q.push_back(8'(k - 8));
      else             exp_q.push_back(8'(8'h40 + k - 15));
    end
    run_full("dly15");

    // Moving average of 4
    do_reset();
    i_mode = 2'd2;
    din_q = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    exp_q = '{8'h3F, 8'h7F, 8'hBF, 8'hFF, 8'hFF, 8'hFF, 8'hBF, 8'h7F, 8'h3F, 8'h00, 8'h00};
    run_full("avg");
    chk("avg_clip", 32'(o_clip), 32'h1);

    // Ramp at half rate through a full wrap, then switch to delay mode
    do_reset();
    i_mode = 2'd3;
    for (int i = 0; i < 258; i++) send_pair(8'(i) ^ 8'h5A, 8'(i), "ramp");
    i_mode = 2'd1;
    i_delay = 4'd2;
    send_pair(8'h77, 8'h5A, "switch0");
    send_pair(8'h88, 8'h5B, "switch1");

    // Peak hold decay and clip set/clear priority
    do_reset();
    i_mode = 2'd0;
    i_sample_en = 1'b1;
    i_ad_data = 8'hFF;
    step();
    i_ad_data = 8'h00;
    step();
    chk("peak_set", 32'(o_led), 32'hFF);
    chk("clip_set", 32'(o_clip), 32'h1);
    for (int j = 1; j <= 16; j++) begin
      step();
      if (j == 15) chk("peak_hold15", 32'(o_led), 32'hFF);
      if (j == 16) chk("peak_dec1", 32'(o_led), 32'hFE);
    end
    for (int j = 1; j <= 16; j++) begin
      step();
      if (j == 15) chk("peak_hold31", 32'(o_led), 32'hFE);
      if (j == 16) chk("peak_dec2", 32'(o_led), 32'hFD);
    end
    i_clip_clr = 1'b1;
    step();
    chk("clip_set_wins", 32'(o_clip), 32'h1);
    i_clip_clr = 1'b0;
    i_ad_data = 8'h55;
    step();
    i_sample_en = 1'b0;
    step();
    i_clip_clr = 1'b1;
    step();
    chk("clip_cleared", 32'(o_clip), 32'h0);
    i_clip_clr = 1'b0;

    // Reset in the middle of a delay stream
    do_reset();
    i_mode = 2'd1;
    i_delay = 4'd1;
    i_sample_en = 1'b1;
    i_ad_data = 8'h11;
    step();
    i_ad_data = 8'h22;
    step();
    i_ad_data = 8'h33;
    step();
    chk("mid_data", 32'(o_da_data), 32'h11);
    reset = 1'b1;
    i_ad_data = 8'h44;
    step();
    chk_zero("mid_rst");
    reset = 1'b0;
    i_sample_en = 1'b0;
    step();
    chk("post_rst_vld", 32'(o_da_valid), 32'h0);
    chk("post_rst_data", 32'(o_da_data), 32'h0);
    send_pair(8'h55, 8'h00, "post_rst0");
    send_pair(8'h66, 8'h55, "post_rst1");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
